// File: rtl/execute_multicycle_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg: shared types and defaults for the execute_multicycle stage.
//   op_e     - 4-bit operation code travelling with each instruction
//   fwd_e    - 2-bit operand-forwarding select (encoding 3 behaves as NONE)
//   ctl_t    - control flags captured alongside an operation
//   state_e  - execute FSM states
//   block_t  - datapath word at the default width
// -----------------------------------------------------------------------------
package exec_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_RADDR_W = 4;

  typedef logic [DEF_WIDTH-1:0] block_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_GT  = 4'd4,
    OP_EQ  = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EXE  = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_e;

  typedef struct packed {
    logic reg_write;
    logic branch;
    logic halt;
  } ctl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/execute_multicycle_if.sv
// -----------------------------------------------------------------------------
// execute_multicycle_if: decode-side request and write-back-side result bundle
// of the execute stage.
//   master modport - the decode/pipeline side (drives op, operands, flush)
//   slave modport  - the execute unit (drives handshake ready and results)
// -----------------------------------------------------------------------------
interface execute_multicycle_if
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RADDR_W = DEF_RADDR_W
);

  // Request side
  logic               in_valid;
  logic               in_ready;
  op_e                op;
  logic [WIDTH-1:0]   val1;
  logic [WIDTH-1:0]   val2;
  logic [WIDTH-1:0]   val3;
  fwd_e               fwd1_sel;
  fwd_e               fwd2_sel;
  logic [WIDTH-1:0]   mem_value;
  logic               is_reg_write;
  logic               is_branch;
  logic               is_halt;
  logic               flush;

  // Result side
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               do_exe_reg_write;
  logic [RADDR_W-1:0] exe_reg_addr;
  logic               do_branch;
  logic [WIDTH-1:0]   branch_address;
  logic               do_halt;
  logic               busy;

  modport master (
    output in_valid, op, val1, val2, val3, fwd1_sel, fwd2_sel, mem_value,
           is_reg_write, is_branch, is_halt, flush,
    input  in_ready, out_valid, result, do_exe_reg_write, exe_reg_addr,
           do_branch, branch_address, do_halt, busy
  );

  modport slave (
    input  in_valid, op, val1, val2, val3, fwd1_sel, fwd2_sel, mem_value,
           is_reg_write, is_branch, is_halt, flush,
    output in_ready, out_valid, result, do_exe_reg_write, exe_reg_addr,
           do_branch, branch_address, do_halt, busy
  );

endinterface

// File: rtl/execute_multicycle_seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load a/b and begin WIDTH iterations
//   abort     - stop the current multiply; no done is produced
//   a, b      - multiplicand / multiplier (sampled on start)
//   done      - high during the final iteration cycle
//   product   - low WIDTH bits of a*b, valid while done is high
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final partial sum is offered combinationally so the caller can
  // register it on the same edge as the last iteration, with no extra cycle.
  assign done    = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign product = w_acc_next;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (abort) begin
      r_run <= 1'b0;
    end else if (start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_multicycle.sv
// -----------------------------------------------------------------------------
// execute_multicycle: execute stage with single-cycle ALU ops and an optional
// iterative multiply, operand forwarding and flush.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of execute_multicycle_if:
//                in_valid/in_ready handshake, op, val1/val2 operands,
//                val3 (dest reg / branch target), fwd1_sel/fwd2_sel,
//                mem_value, control flags, flush;
//                out_valid pulse, result, do_exe_reg_write, exe_reg_addr,
//                do_branch, branch_address, do_halt, busy
// Non-MUL ops complete on the accept edge; MUL completes WIDTH edges later.
// -----------------------------------------------------------------------------
module execute_multicycle
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RADDR_W = DEF_RADDR_W,
  parameter bit          MUL_EN  = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  execute_multicycle_if.slave bus
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  state_e             r_state;
  state_e             w_state_next;

  word_t              r_result;
  logic               r_out_valid;
  logic               r_do_wr;
  logic [RADDR_W-1:0] r_reg_addr;
  logic               r_do_branch;
  word_t              r_branch_addr;
  logic               r_do_halt;

  // Control and target captured while a multiply is running
  ctl_t               r_mul_ctl;
  word_t              r_mul_val3;

  word_t              w_op1;
  word_t              w_op2;
  word_t              w_alu;
  logic               w_accept;
  logic               w_is_mul;
  ctl_t               w_in_ctl;

  logic               w_mul_start;
  logic               w_mul_abort;
  logic               w_mul_done;
  word_t              w_mul_product;

  logic               w_cpl;
  word_t              w_cpl_value;
  ctl_t               w_cpl_ctl;
  word_t              w_cpl_target;

  assign bus.in_ready         = (r_state == ST_IDLE);
  assign bus.busy             = (r_state == ST_MUL);
  assign bus.out_valid        = r_out_valid;
  assign bus.result           = r_result;
  assign bus.do_exe_reg_write = r_do_wr;
  assign bus.exe_reg_addr     = r_reg_addr;
  assign bus.do_branch        = r_do_branch;
  assign bus.branch_address   = r_branch_addr;
  assign bus.do_halt          = r_do_halt;

  assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_is_mul = MUL_EN && (bus.op == OP_MUL);
  assign w_in_ctl = '{reg_write: bus.is_reg_write, branch: bus.is_branch,
                      halt: bus.is_halt};

  // EXE forwarding reads the result register before this edge updates it,
  // which is exactly the previous op's result in a back-to-back chain.
  always_comb begin
    case (bus.fwd1_sel)
      FWD_EXE: w_op1 = r_result;
      FWD_MEM: w_op1 = bus.mem_value;
      default: w_op1 = bus.val1;
    endcase
    case (bus.fwd2_sel)
      FWD_EXE: w_op2 = r_result;
      FWD_MEM: w_op2 = bus.mem_value;
      default: w_op2 = bus.val2;
    endcase
  end

  // OP_MUL only reaches this adder when the multiplier is not built.
  always_comb begin
    w_alu = '0;
    case (bus.op)
      OP_ADD, OP_MUL: w_alu = w_op1 + w_op2;
      OP_SUB:         w_alu = w_op1 - w_op2;
      OP_AND:         w_alu = w_op1 & w_op2;
      OP_OR:          w_alu = w_op1 | w_op2;
      OP_GT:          w_alu = word_t'(w_op1 > w_op2);
      OP_EQ:          w_alu = word_t'(w_op1 == w_op2);
      OP_SHL:         w_alu = w_op1 << w_op2[SH_W-1:0];
      OP_SHR:         w_alu = w_op1 >> w_op2[SH_W-1:0];
      default:        w_alu = '0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (w_mul_start),
        .abort  (w_mul_abort),
        .a      (w_op1),
        .b      (w_op2),
        .done   (w_mul_done),
        .product(w_mul_product)
      );
    end else begin : g_no_mul
      assign w_mul_done    = 1'b0;
      assign w_mul_product = '0;
    end
  endgenerate

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    w_mul_abort  = 1'b0;
    w_cpl        = 1'b0;
    w_cpl_value  = '0;
    w_cpl_ctl    = '0;
    w_cpl_target = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_next = ST_MUL;
            w_mul_start  = 1'b1;
          end else begin
            w_cpl        = 1'b1;
            w_cpl_value  = w_alu;
            w_cpl_ctl    = w_in_ctl;
            w_cpl_target = bus.val3;
          end
        end
      end
      ST_MUL: begin
        // Flush wins over a multiply finishing on the same edge.
        if (bus.flush) begin
          w_state_next = ST_IDLE;
          w_mul_abort  = 1'b1;
        end else if (w_mul_done) begin
          w_state_next = ST_IDLE;
          w_cpl        = 1'b1;
          w_cpl_value  = w_mul_product;
          w_cpl_ctl    = r_mul_ctl;
          w_cpl_target = r_mul_val3;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pulses (out_valid, reg write, branch) clear every cycle without a
  // completion; the data outputs hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_do_wr       <= 1'b0;
      r_do_branch   <= 1'b0;
      r_result      <= '0;
      r_reg_addr    <= '0;
      r_branch_addr <= '0;
      r_do_halt     <= 1'b1;
      r_mul_ctl     <= '0;
      r_mul_val3    <= '0;
    end else begin
      r_out_valid <= w_cpl;
      r_do_wr     <= w_cpl && w_cpl_ctl.reg_write;
      r_do_branch <= w_cpl && w_cpl_ctl.branch && (w_cpl_value != '0);
      if (w_cpl) begin
        r_result      <= w_cpl_value;
        r_reg_addr    <= w_cpl_target[RADDR_W-1:0];
        r_branch_addr <= w_cpl_target;
        r_do_halt     <= w_cpl_ctl.halt;
      end
      if (w_mul_start) begin
        r_mul_ctl  <= w_in_ctl;
        r_mul_val3 <= bus.val3;
      end
    end
  end

endmodule

// File: tb/tb_execute_multicycle.sv
// -----------------------------------------------------------------------------
// tb_execute_multicycle: self-checking bench for execute_multicycle.
// Table-driven back-to-back ALU vectors plus directed multiply, flush and
// MUL_EN=0 sequences. Expected completions go into a scoreboard queue when an
// op is driven and are popped by a monitor whenever out_valid pulses.
// -----------------------------------------------------------------------------
module tb_execute_multicycle;
  import exec_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  execute_multicycle_if #(.WIDTH(W), .RADDR_W(4)) bus1 ();
  execute_multicycle_if #(.WIDTH(W), .RADDR_W(4)) bus0 ();

  execute_multicycle #(.WIDTH(W), .RADDR_W(4), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  execute_multicycle #(.WIDTH(W), .RADDR_W(4), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    op_e         op;
    logic [15:0] v1, v2, v3, mem;
    fwd_e        f1, f2;
    logic        wr, br, halt;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        wr;
    logic [3:0]  addr;
    logic        br;
    logic [15:0] baddr;
    logic        halt;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cpl    = 0;
  logic busy0_seen = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] res, input logic [15:0] v3,
                          input logic wr, input logic br, input logic halt);
    exp_t e;
    e.res   = res;
    e.wr    = wr;
    e.addr  = v3[3:0];
    e.br    = br && (res != 16'd0);
    e.baddr = v3;
    e.halt  = halt;
    sb_q.push_back(e);
  endtask

  task automatic drive1(input op_e op, input logic [15:0] v1, input logic [15:0] v2,
                        input logic [15:0] v3, input logic [15:0] mem,
                        input fwd_e f1, input fwd_e f2,
                        input logic wr, input logic br, input logic halt, input logic fl);
    bus1.in_valid     = 1'b1;
    bus1.op           = op;
    bus1.val1         = v1;
    bus1.val2         = v2;
    bus1.val3         = v3;
    bus1.mem_value    = mem;
    bus1.fwd1_sel     = f1;
    bus1.fwd2_sel     = f2;
    bus1.is_reg_write = wr;
    bus1.is_branch    = br;
    bus1.is_halt      = halt;
    bus1.flush        = fl;
  endtask

  task automatic idle1();
    bus1.in_valid = 1'b0;
    bus1.flush    = 1'b0;
  endtask

  // Counts cycles with in_ready low, bounded so a stuck FSM cannot hang.
  task automatic count_ready_low(output int low);
    low = 0;
    while (!bus1.in_ready && low < 40) begin
      check("mul_busy_high", 32'(bus1.busy), 1);
      low++;
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (bus1.out_valid) begin
        n_cpl++;
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", 32'(bus1.out_valid), 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result",   32'(bus1.result),           32'(mon_e.res));
          check("sb_reg_wr",   32'(bus1.do_exe_reg_write), 32'(mon_e.wr));
          check("sb_reg_addr", 32'(bus1.exe_reg_addr),     32'(mon_e.addr));
          check("sb_branch",   32'(bus1.do_branch),        32'(mon_e.br));
          check("sb_br_addr",  32'(bus1.branch_address),   32'(mon_e.baddr));
          check("sb_halt",     32'(bus1.do_halt),          32'(mon_e.halt));
        end
      end else begin
        check("gated_pulses_idle", 32'({bus1.do_branch, bus1.do_exe_reg_write}), 0);
      end
      if (bus0.busy) busy0_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int low;

    vecs[0]  = '{OP_ADD, 16'd3,     16'd4,     16'h0001, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'd7};
    vecs[1]  = '{OP_SUB, 16'd100,   16'd2,     16'h0002, 16'd0, FWD_EXE,  FWD_NONE, 1'b1, 1'b0, 1'b0, 16'd5};
    vecs[2]  = '{OP_GT,  16'd3,     16'd0,     16'h0003, 16'd9, FWD_NONE, FWD_MEM,  1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{OP_AND, 16'hF0F0,  16'h3C3C,  16'h0004, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h3030};
    vecs[4]  = '{OP_OR,  16'hF000,  16'h000F,  16'h0005, 16'd0, FWD_NONE, FWD_NONE, 1'b0, 1'b0, 1'b1, 16'hF00F};
    vecs[5]  = '{OP_SHL, 16'h0001,  16'h0013,  16'h0006, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h0008};
    vecs[6]  = '{OP_SHR, 16'h8000,  16'h000F,  16'h0007, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[7]  = '{OP_SUB, 16'h0000,  16'h0001,  16'h0008, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[8]  = '{OP_ADD, 16'hFFFF,  16'h0002,  16'h0009, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[9]  = '{OP_EQ,  16'd5,     16'd5,     16'h0040, 16'd0, FWD_NONE, FWD_NONE, 1'b0, 1'b1, 1'b0, 16'h0001};
    vecs[10] = '{OP_EQ,  16'd5,     16'd6,     16'h0080, 16'd0, FWD_NONE, FWD_NONE, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{OP_GT,  16'd9,     16'd3,     16'h000A, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h0001};
    vecs[12] = '{OP_ADD, 16'd10,    16'd20,    16'h000B, 16'd0, fwd_e'(2'd3), fwd_e'(2'd3), 1'b1, 1'b0, 1'b0, 16'd30};
    vecs[13] = '{OP_ADD, 16'd1,     16'd1,     16'h000C, 16'd0, FWD_EXE,  FWD_EXE,  1'b1, 1'b0, 1'b0, 16'd60};
    vecs[14] = '{OP_SHR, 16'hFFFF,  16'h0010,  16'h000D, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[15] = '{OP_ADD, 16'h1111,  16'h0000,  16'h0007, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 16'h1111};

    rst = 1'b1;
    drive1(OP_ADD, 16'd0, 16'd0, 16'd0, 16'd0, FWD_NONE, FWD_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    idle1();
    bus0.in_valid = 1'b0; bus0.op = OP_ADD; bus0.val1 = '0; bus0.val2 = '0; bus0.val3 = '0;
    bus0.mem_value = '0; bus0.fwd1_sel = FWD_NONE; bus0.fwd2_sel = FWD_NONE;
    bus0.is_reg_write = 1'b0; bus0.is_branch = 1'b0; bus0.is_halt = 1'b0; bus0.flush = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_do_halt",   32'(bus1.do_halt),        1);
    check("rst_result",    32'(bus1.result),         0);
    check("rst_out_valid", 32'(bus1.out_valid),      0);
    check("rst_busy",      32'(bus1.busy),           0);
    check("rst_reg_addr",  32'(bus1.exe_reg_addr),   0);
    check("rst_br_addr",   32'(bus1.branch_address), 0);
    check("rst_nomul_halt", 32'(bus0.do_halt),       1);
    @(negedge clk);
    check("rst_in_ready",  32'(bus1.in_ready),       1);
    check("rst_out_valid_after", 32'(bus1.out_valid), 0);

    // Back-to-back table vectors: one completion per cycle
    for (int i = 0; i < 16; i++) begin
      drive1(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].v3, vecs[i].mem,
             vecs[i].f1, vecs[i].f2, vecs[i].wr, vecs[i].br, vecs[i].halt, 1'b0);
      check("vec_in_ready", 32'(bus1.in_ready), 1);
      push_exp(vecs[i].res, vecs[i].v3, vecs[i].wr, vecs[i].br, vecs[i].halt);
      @(negedge clk);
      check("b2b_out_valid", 32'(bus1.out_valid), 1);
    end
    idle1();
    @(negedge clk);
    check("branch_one_cycle", 32'(bus1.do_branch), 0);
    check("table_completions", 32'(n_cpl), 16);

    // Flush in IDLE drops the input; result keeps 0x1111
    drive1(OP_ADD, 16'd1, 16'd1, 16'h000E, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle1();
    check("idle_flush_no_cpl", 32'(bus1.out_valid), 0);
    check("idle_flush_result", 32'(bus1.result), 32'h1111);

    // MUL then an immediately following MUL: no bubble
    drive1(OP_MUL, 16'h0123, 16'h0010, 16'h0003, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(16'h1230, 16'h0003, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle1();
    count_ready_low(low);
    check("mul1_ready_low_cycles", 32'(low), 16);
    check("mul1_out_valid", 32'(bus1.out_valid), 1);
    drive1(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0045, 16'd0, FWD_NONE, FWD_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(16'h0001, 16'h0045, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle1();
    count_ready_low(low);
    check("mul2_ready_low_cycles", 32'(low), 16);

    // Restore a known result, then flush a multiply 5 cycles after accept
    drive1(OP_ADD, 16'h1111, 16'h0000, 16'h0007, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(16'h1111, 16'h0007, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive1(OP_MUL, 16'd3, 16'd3, 16'h000F, 16'd0, FWD_NONE, FWD_NONE, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    idle1();
    repeat (4) @(negedge clk);
    check("flush_busy_before", 32'(bus1.busy), 1);
    bus1.flush = 1'b1;
    @(negedge clk);
    bus1.flush = 1'b0;
    check("flush_busy_after",  32'(bus1.busy),         0);
    check("flush_in_ready",    32'(bus1.in_ready),     1);
    check("flush_out_valid",   32'(bus1.out_valid),    0);
    check("flush_result_kept", 32'(bus1.result),       32'h1111);
    check("flush_addr_kept",   32'(bus1.exe_reg_addr), 7);
    check("flush_halt_kept",   32'(bus1.do_halt),      0);
    repeat (20) @(negedge clk);

    // MUL_EN = 0: MUL behaves as a single-cycle ADD
    bus0.in_valid = 1'b1; bus0.op = OP_MUL; bus0.val1 = 16'd6; bus0.val2 = 16'd7;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check("nomul_out_valid", 32'(bus0.out_valid), 1);
    check("nomul_result",    32'(bus0.result),    13);
    check("nomul_in_ready",  32'(bus0.in_ready),  1);
    repeat (3) @(negedge clk);

    check("nomul_busy_never", 32'(busy0_seen), 0);
    check("sb_queue_empty",   32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
